// File: rtl/apb_requester_nslv.sv
// APB requester driving NUM_SLAVES completers decoded from the top address bits.
// Optional ACCESS timeout enabled by defining APB_REQ_TIMEOUT_EN.
module apb_requester_nslv #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             I_PCLK,
  input  logic                             I_PRESETn,
  input  logic                             I_transfer,
  input  logic                             I_READ_WRITE,
  input  logic [ADDR_WIDTH-1:0]            I_paddr,
  input  logic [DATA_WIDTH-1:0]            I_pwdata,
  output logic                             o_busy,
  output logic                             o_done,
  output logic                             o_error,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic [NUM_SLAVES-1:0]            o_PSEL,
  output logic                             o_PENABLE,
  output logic                             o_PWRITE,
  output logic [ADDR_WIDTH-1:0]            o_PADDR,
  output logic [DATA_WIDTH-1:0]            o_PWDATA,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] I_PRDATA,
  input  logic [NUM_SLAVES-1:0]            I_PREADY,
  input  logic [NUM_SLAVES-1:0]            I_PSLVERR
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } state_t;

  state_t state_q, state_d;

  logic [SEL_BITS-1:0]   idx_q;
  logic [SEL_BITS-1:0]   new_idx;
  logic [31:0]           idx_w;
  logic [31:0]           new_idx_w;
  logic                  new_ok;
  logic                  sel_ready;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  apb_act;
  logic                  tmo_hit;
  logic                  done_d;
  logic                  err_d;
  logic                  load_rd;
  logic                  capture;

  assign new_idx   = I_paddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign new_idx_w = {{(32-SEL_BITS){1'b0}}, new_idx};
  assign idx_w     = {{(32-SEL_BITS){1'b0}}, idx_q};
  assign new_ok    = new_idx_w < $unsigned(NUM_SLAVES);
  assign apb_act   = (state_q == SETUP) || (state_q == ACCESS);
  assign o_busy    = state_q != IDLE;
  assign o_PENABLE = state_q == ACCESS;

  // Only the addressed completer's response lines are looked at.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    o_PSEL    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_w == $unsigned(k)) begin
        sel_rdata = I_PRDATA[k*DATA_WIDTH +: DATA_WIDTH];
        sel_ready = I_PREADY[k];
        sel_err   = I_PSLVERR[k];
        o_PSEL[k] = apb_act;
      end
    end
  end

`ifdef APB_REQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state_q == ACCESS) && !sel_ready &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge I_PCLK or negedge I_PRESETn) begin
    if (!I_PRESETn) begin
      tmo_cnt <= '0;
    end else if (state_q != ACCESS) begin
      tmo_cnt <= '0;
    end else if (!sel_ready) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    load_rd = 1'b0;
    unique case (state_q)
      IDLE: ;
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          done_d  = 1'b1;
          err_d   = sel_err;
          load_rd = !o_PWRITE;
        end else if (tmo_hit) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end
      end
      DERR: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
    // A request on the completion edge is taken without an IDLE gap.
    capture = I_transfer && ((state_q == IDLE) || done_d);
    if (done_d) state_d = IDLE;
    if (capture) state_d = new_ok ? SETUP : DERR;
  end

  always_ff @(posedge I_PCLK or negedge I_PRESETn) begin
    if (!I_PRESETn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      o_PADDR  <= '0;
      o_PWDATA <= '0;
      o_PWRITE <= 1'b0;
      o_done   <= 1'b0;
      o_error  <= 1'b0;
      o_rdata  <= '0;
    end else begin
      state_q <= state_d;
      o_done  <= done_d;
      o_error <= err_d;
      if (load_rd) o_rdata <= sel_rdata;
      if (capture) begin
        idx_q    <= new_idx;
        o_PADDR  <= I_paddr;
        o_PWDATA <= I_pwdata;
        o_PWRITE <= I_READ_WRITE;
      end
    end
  end

endmodule

// File: doc/apb_requester_nslv.md
APB_REQUESTER_NSLV -- requirements
Module: apb_requester_nslv

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 8, data bus width; ADDR_WIDTH, default 8, address width; NUM_SLAVES, default 4, APB completers (1..16); SEL_BITS, default 2, top address bits used for slave decode; TIMEOUT_CYCLES, default 16, ACCESS wait limit.
REQ-002 SHALL have ports: I_PCLK  in  1  clock, rising edge; I_PRESETn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have request-side ports: I_transfer  in  1  request valid; I_READ_WRITE  in  1  1=write, 0=read; I_paddr  in  ADDR_WIDTH  address; I_pwdata  in  DATA_WIDTH  write data.
REQ-004 SHALL have response ports: o_busy  out  1  transfer in progress; o_done  out  1  one-cycle completion pulse; o_error  out  1  error status, valid with o_done; o_rdata  out  DATA_WIDTH  read data, valid with o_done.
REQ-005 SHALL have APB ports: o_PSEL  out  NUM_SLAVES  one-hot select; o_PENABLE  out  1; o_PWRITE  out  1; o_PADDR  out  ADDR_WIDTH; o_PWDATA  out  DATA_WIDTH; I_PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave k in bits [k*DATA_WIDTH +: DATA_WIDTH]; I_PREADY  in  NUM_SLAVES; I_PSLVERR  in  NUM_SLAVES.

Function
REQ-006 SHALL implement the states IDLE, SETUP, ACCESS and DERR.
REQ-007 In IDLE, I_transfer=1 at a clock edge SHALL register I_paddr, I_pwdata and I_READ_WRITE; the decode index is I_paddr[ADDR_WIDTH-1 -: SEL_BITS].
REQ-008 If the index is below NUM_SLAVES, the FSM SHALL go to SETUP; otherwise it SHALL go to DERR.
REQ-009 In SETUP, o_PSEL[index] SHALL be 1 and o_PENABLE 0; the next state SHALL be ACCESS unconditionally.
REQ-010 In ACCESS, o_PSEL[index]=1 and o_PENABLE=1; o_PADDR, o_PWDATA and o_PWRITE SHALL be stable from SETUP until exit.
REQ-011 ACCESS SHALL hold while I_PREADY[index]=0, with no limit unless REQ-019 applies; only the selected slave's PREADY/PSLVERR/PRDATA are observed.
REQ-012 At the edge where ACCESS and I_PREADY[index]=1, the block SHALL register o_done=1 for one cycle and set o_error=I_PSLVERR[index].
REQ-013 On that same edge, a read SHALL also set o_rdata to the selected PRDATA slice; on a write, o_rdata SHALL hold its prior value.
REQ-014 DERR SHALL last one cycle with all o_PSEL=0, then pulse o_done=1 with o_error=1 and return to IDLE; no APB cycle is issued.
REQ-015 On completion, if I_transfer=1, the new request SHALL be captured and the FSM SHALL enter SETUP or DERR directly (back-to-back, no IDLE cycle); otherwise it SHALL return to IDLE.
REQ-016 o_busy SHALL be 1 in SETUP, ACCESS and DERR; I_transfer SHALL be ignored while busy except on the completion edge.
REQ-017 Minimum latency SHALL be: request edge N, SETUP in cycle N+1, ACCESS in cycle N+2, o_done in cycle N+3.

Reset
REQ-018 Asserting I_PRESETn low SHALL immediately force: state IDLE, o_PSEL=0, o_PENABLE=0, o_PWRITE=0, o_PADDR=0, o_PWDATA=0, o_rdata=0, o_done=0, o_error=0, o_busy=0, timeout counter=0; this SHALL abort any transfer in flight without issuing o_done.

Configuration
REQ-019 With macro APB_REQ_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment each ACCESS cycle with PREADY=0; when it reaches TIMEOUT_CYCLES-1 with PREADY still 0, the block SHALL drop o_PSEL/o_PENABLE, pulse o_done with o_error=1, and hold o_rdata.
REQ-020 Without APB_REQ_TIMEOUT_EN, no counter SHALL be synthesised and ACCESS SHALL wait indefinitely.

Verification
REQ-021 Write 0x5A to addr 0x41 (slave 1), PREADY=1 immediately -> o_PSEL=0010 SETUP then ACCESS, PWDATA=0x5A, o_done at N+3, o_error=0.
REQ-022 Read addr 0xC3 (slave 3), slave 3 PRDATA=0xA5, PREADY low 3 ACCESS cycles -> o_done at N+6, o_rdata=0xA5, other slaves' data ignored.
REQ-023 NUM_SLAVES=3, read addr 0xF0 -> no PSEL asserted, o_done at N+2, o_error=1.
REQ-024 Back-to-back write slave 0 then read slave 2 with I_transfer held high -> second SETUP in the cycle after the first completion, no IDLE gap.
REQ-025 Slave returns PSLVERR=1 with PREADY -> o_error=1 with o_done; I_PRESETn low mid-ACCESS -> all outputs 0 asynchronously, no o_done.
REQ-026 APB_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, PREADY stuck at 0 -> o_done with o_error=1 after 16 ACCESS cycles; without the macro, still waiting at 100 cycles.
